mem_port_arbiter: RTL

Arbiter and sequencer sharing the single core memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multicycle core. It accepts one request at a time from either requester, drives it onto the memory port with a valid/ready handshake, and waits for the response. It returns the response to the owning requester and watchdogs the transaction against a hung memory. Exactly one transaction is outstanding at any time.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle around the shared core memory port: IFU and LSU requester
// channels plus the memory-side request/response channel.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_resp_valid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_resp_err;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_resp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_resp_err;

  // Arbiter view: serves the requesters, masters the memory port.
  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  // Environment view: requesters and the memory itself.
  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU and LSU: round-robin on ties,
// one outstanding transaction, watchdog turns a hung memory into an error response.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t              state, state_nxt;
  owner_t              owner, last_grant, winner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    cnt;

  logic                ifu_ready, lsu_ready, accept;
  logic                progress, timeout, resp_fire;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  logic                ifu_resp_valid_q, ifu_resp_err_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic                lsu_resp_valid_q, lsu_resp_err_q;
  logic [DATA_W-1:0]   lsu_rdata_q;

  always_comb begin
    winner = OWN_IFU;
    if (bus.ifu_req_valid && bus.lsu_req_valid)
      winner = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
    else if (bus.lsu_req_valid)
      winner = OWN_LSU;
  end

  // Readies are gated by rst_n so every output reads 0 while reset is held.
  assign ifu_ready = rst_n && (state == IDLE) && bus.ifu_req_valid && (winner == OWN_IFU);
  assign lsu_ready = rst_n && (state == IDLE) && bus.lsu_req_valid && (winner == OWN_LSU);
  assign accept    = ifu_ready || lsu_ready;

  assign progress  = ((state == REQ) && bus.mem_req_ready) ||
                     ((state == RESP) && bus.mem_resp_valid);
  assign timeout   = (state != IDLE) && (cnt == CNT_W'(TIMEOUT - 1)) && !progress;
  assign resp_fire = ((state == RESP) && bus.mem_resp_valid) || timeout;

  always_comb begin
    resp_rdata = '0;
    resp_err   = 1'b1;
    if (!timeout) begin
      resp_err = bus.mem_resp_err;
      if (!((owner == OWN_LSU) && wen_q))
        resp_rdata = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (bus.mem_req_ready) state_nxt = RESP;
            else if (timeout)      state_nxt = IDLE;
      RESP: if (bus.mem_resp_valid || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner            <= OWN_IFU;
      last_grant       <= OWN_IFU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      cnt              <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        cnt        <= '0;
        if (winner == OWN_LSU) begin
          addr_q  <= bus.lsu_addr;
          wen_q   <= bus.lsu_wen;
          wdata_q <= bus.lsu_wdata;
          wmask_q <= bus.lsu_wmask;
        end else begin
          addr_q  <= bus.ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (resp_fire) begin
        if (owner == OWN_LSU) begin
          lsu_resp_valid_q <= 1'b1;
          lsu_rdata_q      <= resp_rdata;
          lsu_resp_err_q   <= resp_err;
        end else begin
          ifu_resp_valid_q <= 1'b1;
          ifu_rdata_q      <= resp_rdata;
          ifu_resp_err_q   <= resp_err;
        end
      end
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.mem_req_valid  = (state == REQ);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign busy               = (state != IDLE);
endmodule
